// File: rtl/Uart_Tx_enum.sv
// Uart_Tx_enum: shared FSM state type and register map for the memory-mapped UART transmitter
package Uart_Tx_enum;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;
    localparam logic [3:0] DIV_OFF    = 4'h8;

    localparam int ST_BUSY = 0;
    localparam int ST_HOLD = 1;
    localparam int ST_OVR  = 2;

    // Register slot addressed by a byte offset (word-aligned map)
    function automatic logic [1:0] regSlot(input logic [3:0] off);
        return off[3:2];
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: counts 0..div-1 and flags the last cycle of each bit period
module baud_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count;

    assign tick = !clear && (count == div - DIV_WIDTH'(1));

    // Bit-period counter, held at zero while the transmitter is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else
            count <= (clear || tick) ? '0 : count + DIV_WIDTH'(1);
    end

endmodule

// File: rtl/uart_tx_mm.sv
// uart_tx_mm: memory-mapped 8N1 UART transmitter with a one-byte holding buffer
module uart_tx_mm
    import Uart_Tx_enum::*;
#(
    parameter int                   DATA_WIDTH  = 32,
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd434
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  we,
    input  logic                  re,
    input  logic [3:0]            addr,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  tx,
    output logic                  busy
);

    uart_tx_state_t state, nextState;
    logic [7:0] shiftReg, holdByte;
    logic [DIV_WIDTH-1:0] divReg, frameDiv;
    logic [2:0] bitIdx;
    logic holdFull, overrun, tick;
    logic wrTx, wrStatus, wrDiv, stopEnd, load, useWd, toHold, setOverrun, holdFullNext;
    logic unusedBits;

    assign unusedBits = ^{wd[DATA_WIDTH-1:DIV_WIDTH], addr[1:0]};

    assign wrTx     = sel && we && addr[3:2] == regSlot(TXDATA_OFF);
    assign wrStatus = sel && we && addr[3:2] == regSlot(STATUS_OFF);
    assign wrDiv    = sel && we && addr[3:2] == regSlot(DIV_OFF);

    // A frame starts either from idle or straight out of a finishing stop bit
    assign stopEnd      = state == STOP && tick;
    assign load         = nextState == START && state != START;
    assign useWd        = load && !(stopEnd && holdFull);
    assign toHold       = wrTx && !useWd && (!holdFull || stopEnd);
    assign setOverrun   = wrTx && !useWd && holdFull && !stopEnd;
    assign holdFullNext = toHold ? 1'b1 : (load && !useWd) ? 1'b0 : holdFull;

    baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) baudGen (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .div   (frameDiv),
        .tick  (tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next-state: each non-idle state lasts one bit period per tick
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = wrTx ? START : IDLE;
            START:   nextState = tick ? DATA : START;
            DATA:    nextState = (tick && bitIdx == 3'd7) ? STOP : DATA;
            STOP:    nextState = tick ? ((holdFull || wrTx) ? START : IDLE) : STOP;
            default: nextState = IDLE;
        endcase
    end

    // Serial line level for the current state
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shiftReg[bitIdx];
            default: tx = 1'b1;
        endcase
    end

    // Frame datapath: shift byte, holding buffer, bit index, per-frame divisor
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg <= '0;
            holdByte <= '0;
            holdFull <= 1'b0;
            bitIdx   <= '0;
            frameDiv <= DEFAULT_DIV;
            busy     <= 1'b0;
        end else begin
            holdFull <= holdFullNext;
            busy     <= nextState != IDLE || holdFullNext;
            if (toHold)
                holdByte <= wd[7:0];
            if (load) begin
                shiftReg <= useWd ? wd[7:0] : holdByte;
                frameDiv <= divReg;
            end
            if (tick)
                bitIdx <= state == DATA ? bitIdx + 3'd1 : 3'd0;
        end
    end

    // Control registers: divisor (zero promoted to one) and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divReg  <= DEFAULT_DIV;
            overrun <= 1'b0;
        end else begin
            overrun <= setOverrun || (overrun && !(wrStatus && wd[ST_OVR]));
            if (wrDiv)
                divReg <= wd[DIV_WIDTH-1:0] == '0 ? DIV_WIDTH'(1) : wd[DIV_WIDTH-1:0];
        end
    end

    // Combinational read mux, zero when not selected for read
    always_comb begin
        rd = '0;
        if (sel && re) begin
            if (addr[3:2] == regSlot(STATUS_OFF)) begin
                rd[ST_BUSY] = busy;
                rd[ST_HOLD] = holdFull;
                rd[ST_OVR]  = overrun;
            end else if (addr[3:2] == regSlot(DIV_OFF)) begin
                rd = DATA_WIDTH'(divReg);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_mm.sv
// tb_uart_tx_mm: directed self-checking bench for the memory-mapped UART transmitter
module tb_uart_tx_mm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rd;
    logic        tx;
    logic        busy;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;
    int cyc = 0;
    int s;
    logic [31:0] rv;
    logic txLog [0:2047];
    logic busyLog [0:2047];

    uart_tx_mm #(
        .DATA_WIDTH  (32),
        .DIV_WIDTH   (16),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .we   (we),
        .re   (re),
        .addr (addr),
        .wd   (wd),
        .rd   (rd),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Record the serial line and busy once per cycle, away from the active edge
    always @(negedge clk) begin
        txLog[cyc[10:0]]   <= tx;
        busyLog[cyc[10:0]] <= busy;
        cyc                <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; wd = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0; wd = 32'h0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        sel = 1'b1; re = 1'b1; addr = a;
        #1;
        v = rd;
        sel = 1'b0; re = 1'b0;
    endtask

    // Expected 8N1 waveform: start 0, data LSB first, stop 1, each held d cycles
    task automatic checkFrame(input string tag, input int start, input logic [7:0] b, input int d);
        for (int k = 0; k < 10 * d; k++) begin
            int pos;
            int i;
            logic e;
            pos = k / d;
            i = start + k;
            e = pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : b[pos-1];
            checkBit(tag, txLog[i[10:0]], e);
        end
    endtask

    task automatic logBusy(input string tag, input int i, input logic exp);
        checkBit(tag, busyLog[i[10:0]], exp);
    endtask

    task automatic logTx(input string tag, input int i, input logic exp);
        checkBit(tag, txLog[i[10:0]], exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        checkBit("rst_tx", tx, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        busRead(4'h4, rv); check("rst_status", rv, 32'h0);
        busRead(4'h8, rv); check("rst_div", rv, 32'h1B2);
        busRead(4'h0, rv); check("txdata_reads0", rv, 32'h0);
        busWrite(4'hC, 32'hFFFF_FFFF);
        busRead(4'hC, rv); check("unmapped_reads0", rv, 32'h0);
        busRead(4'h8, rv); check("unmapped_write_div", rv, 32'h1B2);
        busRead(4'h4, rv); check("unmapped_write_status", rv, 32'h0);
        @(negedge clk);
        sel = 1'b1; addr = 4'h8;
        #1;
        check("no_re_reads0", rd, 32'h0);
        sel = 1'b0;

        // Single frame, DIV=4
        busWrite(4'h8, 32'd4);
        busRead(4'h8, rv); check("div4", rv, 32'd4);
        busWrite(4'h0, 32'h55);
        s = cyc;
        repeat (42) @(negedge clk);
        checkFrame("frame_55", s, 8'h55, 4);
        logBusy("busy_55_first", s, 1'b1);
        logBusy("busy_55_last", s + 39, 1'b1);
        logBusy("busy_55_fall", s + 40, 1'b0);
        logTx("idle_55", s + 40, 1'b1);

        // Back-to-back frames through the holding buffer, DIV=2
        busWrite(4'h8, 32'd2);
        busWrite(4'h0, 32'hA3);
        s = cyc;
        busWrite(4'h0, 32'h0F);
        busRead(4'h4, rv); check("status_hold", rv, 32'h3);
        repeat (42) @(negedge clk);
        checkFrame("frame_A3", s, 8'hA3, 2);
        checkFrame("frame_0F", s + 20, 8'h0F, 2);
        logBusy("busy_b2b_fall", s + 40, 1'b0);
        logTx("idle_b2b", s + 40, 1'b1);

        // Overrun: third byte dropped, sticky until cleared
        busWrite(4'h0, 32'h11);
        s = cyc;
        busWrite(4'h0, 32'h22);
        busWrite(4'h0, 32'h33);
        busRead(4'h4, rv); check("status_overrun", rv, 32'h7);
        busWrite(4'h4, 32'h4);
        busRead(4'h4, rv); check("status_cleared", rv, 32'h3);
        repeat (45) @(negedge clk);
        checkFrame("frame_11", s, 8'h11, 2);
        checkFrame("frame_22", s + 20, 8'h22, 2);
        logBusy("busy_ovr_fall", s + 40, 1'b0);
        for (int k = 40; k < 45; k++) logTx("dropped_33_idle", s + k, 1'b1);

        // DIV=0 is stored as 1: ten-cycle frame
        busWrite(4'h8, 32'd0);
        busRead(4'h8, rv); check("div0_as1", rv, 32'd1);
        busWrite(4'h0, 32'h5A);
        s = cyc;
        repeat (12) @(negedge clk);
        checkFrame("frame_5A", s, 8'h5A, 1);
        logBusy("busy_5A_last", s + 9, 1'b1);
        logBusy("busy_5A_fall", s + 10, 1'b0);

        // DIV change mid-frame applies only to the next frame
        busWrite(4'h0, 32'hC6);
        s = cyc;
        busWrite(4'h0, 32'h39);
        busWrite(4'h8, 32'd8);
        busRead(4'h8, rv); check("div8", rv, 32'd8);
        repeat (92) @(negedge clk);
        checkFrame("frame_C6_old_div", s, 8'hC6, 1);
        checkFrame("frame_39_new_div", s + 10, 8'h39, 8);
        logBusy("busy_39_fall", s + 90, 1'b0);

        // Asynchronous reset during data bit 3
        busWrite(4'h0, 32'h00);
        s = cyc;
        repeat (36) @(negedge clk);
        checkBit("pre_reset_tx", tx, 1'b0);
        checkBit("pre_reset_busy", busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkBit("async_rst_tx", tx, 1'b1);
        checkBit("async_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        busRead(4'h4, rv); check("post_rst_status", rv, 32'h0);
        busRead(4'h8, rv); check("post_rst_div", rv, 32'h1B2);
        checkBit("post_rst_tx", tx, 1'b1);
        busWrite(4'h8, 32'd3);
        busWrite(4'h0, 32'h96);
        s = cyc;
        repeat (32) @(negedge clk);
        checkFrame("frame_96", s, 8'h96, 3);
        logBusy("busy_96_fall", s + 30, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
